splitt_pulse_scheduler: RTL and testbench

- Clocked scheduler that shares one toggle-encoded splitter fan-out input among N requesters.
- Every emitted pulse is a level flip on output `a`, the same encoding the splitter cells use: posedge or negedge = one pulse.
- Enforces the splitter's minimum inter-pulse spacing (critical time) as a cycle gap.
- Grants are arbitrated round-robin and buffered per requester, so no pulse closer than the critical time reaches the tree.

---
 rtl/splitt_pulse_scheduler.sv | 142 ++++++++++++++
 tb/tb_splitt_pulse_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/splitt_pulse_scheduler.sv
// Round-robin scheduler: shares one toggle-encoded splitter input among N_REQ requesters.
// One-edge request-to-flip latency; pending counters absorb requests during GAP, saturating with sticky overflow.
module splitt_pulse_scheduler #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 3,
  parameter int MIN_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic                     a,
  output logic                     fire,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     pending_any,
  output logic                     busy,
  output logic [N_REQ-1:0]         overflow
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, GAP} state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0] cnt [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant_vec;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  idx;
  logic [ID_W:0]    sum;
  logic             found;
  logic             win;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = (cnt[i] != '0);
    end
  end

  assign pending_any = |eligible;
  assign busy        = (state == GAP);

  // First eligible index at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win = (state == IDLE) && found;

  always_comb begin
    grant_vec = '0;
    if (win) begin
      grant_vec[winner] = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (win && (MIN_GAP > 1)) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_W'(MIN_GAP - 1);
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        gap_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= 1'b0;
      fire     <= 1'b0;
      grant_id <= '0;
      ptr      <= '0;
      overflow <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      a    <= a ^ win;
      fire <= win;
      if (win) begin
        grant_id <= winner;
        ptr      <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
      end
      // A request and a grant on the same edge cancel, so a saturated counter can still accept it.
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && !grant_vec[i]) begin
          if (cnt[i] == CNT_MAX) begin
            overflow[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else if (!req[i] && grant_vec[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_splitt_pulse_scheduler.sv
// Directed bench for splitt_pulse_scheduler with default parameters (N_REQ=4, CNT_W=3, MIN_GAP=2).
module tb_splitt_pulse_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       a;
  logic       fire;
  logic [1:0] grant_id;
  logic       pending_any;
  logic       busy;
  logic [3:0] overflow;

  int total = 0;
  int bad   = 0;
  int g2_burst = 0;
  int g2_after = 0;

  splitt_pulse_scheduler #(.N_REQ(4), .CNT_W(3), .MIN_GAP(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .a           (a),
    .fire        (fire),
    .grant_id    (grant_id),
    .pending_any (pending_any),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    tick();
    chk("rst_a", a, 0);
    chk("rst_fire", fire, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pend", pending_any, 0);
    tick();
    rst = 1'b0;

    // Single request: flip one edge after capture, then quiet.
    req = 4'b0001;
    tick();
    req = '0;
    chk("s1_a_e1", a, 0);
    chk("s1_pend_e1", pending_any, 1);
    tick();
    chk("s1_a_e2", a, 1);
    chk("s1_fire_e2", fire, 1);
    chk("s1_gid_e2", grant_id, 0);
    chk("s1_pend_e2", pending_any, 0);
    chk("s1_busy_e2", busy, 1);
    tick();
    chk("s1_fire_e3", fire, 0);
    chk("s1_busy_e3", busy, 0);
    tick();
    tick();
    chk("s1_a_hold", a, 1);
    chk("s1_fire_hold", fire, 0);

    // Spacing: three held requests give flips two edges apart.
    req = 4'b0001;
    tick();
    chk("sp_a_e1", a, 1);
    tick();
    chk("sp_a_e2", a, 0);
    chk("sp_fire_e2", fire, 1);
    chk("sp_busy_e2", busy, 1);
    tick();
    req = '0;
    chk("sp_a_e3", a, 0);
    chk("sp_fire_e3", fire, 0);
    chk("sp_busy_e3", busy, 0);
    tick();
    chk("sp_a_e4", a, 1);
    chk("sp_fire_e4", fire, 1);
    chk("sp_busy_e4", busy, 1);
    tick();
    chk("sp_a_e5", a, 1);
    chk("sp_fire_e5", fire, 0);
    tick();
    chk("sp_a_e6", a, 0);
    chk("sp_fire_e6", fire, 1);
    tick();
    chk("sp_pend_e7", pending_any, 0);
    chk("sp_fire_e7", fire, 0);

    // Round robin from a fresh pointer.
    do_reset();
    req = 4'b1111;
    tick();
    req = '0;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("rr_fire", fire, 1);
      chk("rr_gid", grant_id, r);
      chk("rr_a", a, (r % 2 == 0) ? 1 : 0);
      tick();
      chk("rr_gap_fire", fire, 0);
      chk("rr_gid_hold", grant_id, r);
    end
    req = 4'b1001;
    tick();
    req = '0;
    chk("rr2_fire_e0", fire, 0);
    tick();
    chk("rr2_fire_a", fire, 1);
    chk("rr2_gid_a", grant_id, 0);
    chk("rr2_a_a", a, 1);
    tick();
    tick();
    chk("rr2_fire_b", fire, 1);
    chk("rr2_gid_b", grant_id, 3);
    chk("rr2_a_b", a, 0);

    // Saturation: others keep the arbiter rotating while requester 2 bursts.
    do_reset();
    req = 4'b1011;
    tick();
    tick();
    req = 4'b0100;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (fire && grant_id == 2'd2) g2_burst++;
      if (i == 7) chk("sat_ovf_pre", overflow, 4'b0000);
    end
    req = '0;
    chk("sat_ovf", overflow, 4'b0100);
    chk("sat_g2_burst", g2_burst, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire && grant_id == 2'd2) g2_after++;
    end
    chk("sat_g2_after", g2_after, 7);
    chk("sat_ovf_sticky", overflow, 4'b0100);
    chk("sat_pend_drained", pending_any, 0);

    // Simultaneous increment and decrement on requester 1.
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    req = '0;
    chk("sim_fire_a", fire, 1);
    chk("sim_gid_a", grant_id, 1);
    chk("sim_pend_a", pending_any, 1);
    chk("sim_a_a", a, 1);
    tick();
    chk("sim_fire_gap", fire, 0);
    chk("sim_a_gap", a, 1);
    tick();
    chk("sim_fire_b", fire, 1);
    chk("sim_gid_b", grant_id, 1);
    chk("sim_a_b", a, 0);
    chk("sim_pend_b", pending_any, 0);

    // Reset asserted mid-GAP with a=1 and requests still queued.
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    req = '0;
    tick();
    chk("mr_pre_a", a, 1);
    chk("mr_pre_busy", busy, 1);
    chk("mr_pre_pend", pending_any, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("mr_a", a, 0);
    chk("mr_busy", busy, 0);
    chk("mr_pend", pending_any, 0);
    chk("mr_fire", fire, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_quiet_a", a, 0);
      chk("mr_quiet_fire", fire, 0);
    end
    req = 4'b1001;
    tick();
    req = '0;
    tick();
    chk("mr_first_fire", fire, 1);
    chk("mr_first_gid", grant_id, 0);
    chk("mr_first_a", a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
